// File: rtl/riot_6532.sv
// riot_6532: MOS 6532 RIOT with 128x8 RAM, two I/O ports with DDRs and an interval timer.
module riot_6532 #(
    parameter int RAM_AW = 7
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       CS,
    input  logic       RS_n,
    input  logic [6:0] A,
    input  logic [7:0] Din,
    output logic [7:0] Dout,
    input  logic       R_W_n,
    input  logic [7:0] PA_in,
    output logic [7:0] PA_out,
    output logic [7:0] PA_oe,
    input  logic [7:0] PB_in,
    output logic [7:0] PB_out,
    output logic [7:0] PB_oe,
    output logic       IRQ_n
);
    logic [7:0] mem [2**RAM_AW];
    logic [7:0] ora_q, ora_d, ddra_q, ddra_d, orb_q, orb_d, ddrb_q, ddrb_d;
    logic [7:0] timer_q, timer_d;
    logic [9:0] pre_q, pre_d, lim;
    logic [1:0] div_q, div_d;
    logic       fast_q, fast_d, flag_q, flag_d, irqen_q, irqen_d;
    logic       wr, rd, io, tm, tm_wr, tm_rd, tick, wrap;
    logic [7:0] pa_rd, pb_rd;

    assign wr    = CS & ~R_W_n;
    assign rd    = CS & R_W_n;
    assign io    = RS_n & ~A[2];
    assign tm    = RS_n & A[2];
    assign tm_wr = wr & tm & A[4];
    assign tm_rd = rd & tm & ~A[0];
    assign lim   = div_q == 2'd0 ? 10'd0 : div_q == 2'd1 ? 10'd7 : div_q == 2'd2 ? 10'd63 : 10'd1023;
    // after the first wrap the prescaler is bypassed and the timer ticks every cycle
    assign tick  = fast_q | (pre_q == lim);
    assign wrap  = tick & (timer_q == 8'd0);
    assign pa_rd = (ddra_q & ora_q) | (~ddra_q & PA_in);
    assign pb_rd = (ddrb_q & orb_q) | (~ddrb_q & PB_in);

    always_comb begin
        ora_d   = (wr & io & A[1:0] == 2'd0) ? Din : ora_q;
        ddra_d  = (wr & io & A[1:0] == 2'd1) ? Din : ddra_q;
        orb_d   = (wr & io & A[1:0] == 2'd2) ? Din : orb_q;
        ddrb_d  = (wr & io & A[1:0] == 2'd3) ? Din : ddrb_q;
        timer_d = tm_wr ? Din : tick ? timer_q - 8'd1 : timer_q;
        pre_d   = (tm_wr | tick) ? 10'd0 : pre_q + 10'd1;
        div_d   = tm_wr ? A[1:0] : div_q;
        fast_d  = tm_wr ? 1'b0 : fast_q | wrap;
        flag_d  = tm_wr ? 1'b0 : wrap ? 1'b1 : tm_rd ? 1'b0 : flag_q;
        irqen_d = (tm_wr | tm_rd) ? A[3] : irqen_q;
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            ora_q   <= 8'h00;
            ddra_q  <= 8'h00;
            orb_q   <= 8'h00;
            ddrb_q  <= 8'h00;
            timer_q <= 8'hFF;
            pre_q   <= 10'd0;
            div_q   <= 2'd3;
            fast_q  <= 1'b0;
            flag_q  <= 1'b0;
            irqen_q <= 1'b0;
        end else begin
            ora_q   <= ora_d;
            ddra_q  <= ddra_d;
            orb_q   <= orb_d;
            ddrb_q  <= ddrb_d;
            timer_q <= timer_d;
            pre_q   <= pre_d;
            div_q   <= div_d;
            fast_q  <= fast_d;
            flag_q  <= flag_d;
            irqen_q <= irqen_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr & ~RS_n) mem[A[RAM_AW-1:0]] <= Din;
    end

    always_comb begin
        Dout = 8'h00;
        if (CS)
            Dout = ~RS_n ? mem[A[RAM_AW-1:0]] :
                   ~A[2] ? (A[1:0] == 2'd0 ? pa_rd : A[1:0] == 2'd1 ? ddra_q : A[1:0] == 2'd2 ? pb_rd : ddrb_q) :
                   A[0]  ? {flag_q, 7'b0} : timer_q;
    end

    assign PA_out = ora_q;
    assign PA_oe  = ddra_q;
    assign PB_out = orb_q;
    assign PB_oe  = ddrb_q;
    assign IRQ_n  = ~(flag_q & irqen_q);
endmodule

// File: tb/tb_riot_6532.sv
// tb_riot_6532: directed checks of RAM, ports, timer countdown, IRQ, collisions and reset.
module tb_riot_6532;
    logic       CLK = 1'b0, RES = 1'b1, CS = 1'b0, RS_n = 1'b0, R_W_n = 1'b1;
    logic [6:0] A = 7'h00;
    logic [7:0] Din = 8'h00, PA_in = 8'h00, PB_in = 8'h00;
    logic [7:0] Dout, PA_out, PA_oe, PB_out, PB_oe;
    logic       IRQ_n;
    int checks = 0, errors = 0;

    riot_6532 dut (
        .CLK(CLK), .RES(RES), .CS(CS), .RS_n(RS_n), .A(A), .Din(Din), .Dout(Dout),
        .R_W_n(R_W_n), .PA_in(PA_in), .PA_out(PA_out), .PA_oe(PA_oe),
        .PB_in(PB_in), .PB_out(PB_out), .PB_oe(PB_oe), .IRQ_n(IRQ_n)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string t, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", t, got, exp);
        end
    endtask

    task automatic idle();
        CS = 1'b0;
        R_W_n = 1'b1;
    endtask

    task automatic wr_cyc(input logic rs, input logic [6:0] a, input logic [7:0] d);
        CS = 1'b1; RS_n = rs; R_W_n = 1'b0; A = a; Din = d;
        @(negedge CLK);
        idle();
    endtask

    task automatic rd_chk(input string t, input logic rs, input logic [6:0] a, input logic [7:0] e);
        CS = 1'b1; RS_n = rs; R_W_n = 1'b1; A = a;
        #1 chk(t, Dout, e);
        @(negedge CLK);
        idle();
    endtask

    initial begin
        #1;
        chk("rst_pa_out", PA_out, 8'h00);
        chk("rst_pa_oe", PA_oe, 8'h00);
        chk("rst_irq", {7'b0, IRQ_n}, 8'h01);
        chk("cs0_dout", Dout, 8'h00);
        @(negedge CLK);
        RES = 1'b0;
        rd_chk("rst_timer", 1'b1, 7'h04, 8'hFF);
        rd_chk("rst_flag", 1'b1, 7'h05, 8'h00);

        wr_cyc(1'b0, 7'h00, 8'hA5);
        wr_cyc(1'b0, 7'h7F, 8'h3C);
        rd_chk("ram00", 1'b0, 7'h00, 8'hA5);
        rd_chk("ram7f", 1'b0, 7'h7F, 8'h3C);
        RS_n = 1'b0; A = 7'h00;
        #1 chk("ram_cs0", Dout, 8'h00);
        @(negedge CLK);

        PA_in = 8'h5F; PB_in = 8'hC8;
        wr_cyc(1'b1, 7'h01, 8'hF0);
        wr_cyc(1'b1, 7'h00, 8'hAA);
        wr_cyc(1'b1, 7'h03, 8'h0F);
        wr_cyc(1'b1, 7'h02, 8'h33);
        rd_chk("porta", 1'b1, 7'h00, 8'hAF);
        rd_chk("ddra", 1'b1, 7'h01, 8'hF0);
        rd_chk("portb", 1'b1, 7'h02, 8'hC3);
        chk("pa_oe", PA_oe, 8'hF0);
        chk("pa_out", PA_out, 8'hAA);
        chk("pb_oe", PB_oe, 8'h0F);
        wr_cyc(1'b1, 7'h04, 8'h77);
        rd_chk("edge_ctl_ignored", 1'b1, 7'h01, 8'hF0);

        // V=2, D=64 written in cycle 0
        wr_cyc(1'b1, 7'h16, 8'd2);
        for (int c = 1; c <= 194; c++) begin
            case (c)
                64:  rd_chk("t64", 1'b1, 7'h04, 8'd2);
                65:  rd_chk("t65", 1'b1, 7'h04, 8'd1);
                128: rd_chk("t128", 1'b1, 7'h04, 8'd1);
                129: rd_chk("t129", 1'b1, 7'h04, 8'd0);
                192: rd_chk("t192", 1'b1, 7'h04, 8'd0);
                193: rd_chk("t193_flag", 1'b1, 7'h05, 8'h80);
                194: rd_chk("t194", 1'b1, 7'h04, 8'hFE);
                default: @(negedge CLK);
            endcase
        end

        // V=0, D=1, irq enabled
        wr_cyc(1'b1, 7'h1C, 8'd0);
        #1 chk("irq_c1", {7'b0, IRQ_n}, 8'h01);
        @(negedge CLK);
        #1 chk("irq_c2", {7'b0, IRQ_n}, 8'h00);
        @(negedge CLK);
        rd_chk("flag_rd_c3", 1'b1, 7'h0D, 8'h80);
        chk("irq_after_flag_rd", {7'b0, IRQ_n}, 8'h00);
        rd_chk("timer_rd_c4", 1'b1, 7'h0C, 8'hFD);
        #1 chk("irq_cleared", {7'b0, IRQ_n}, 8'h01);
        rd_chk("flag_cleared", 1'b1, 7'h0D, 8'h00);

        // timer read in the wrap cycle
        wr_cyc(1'b1, 7'h14, 8'd0);
        rd_chk("wrap_rd", 1'b1, 7'h04, 8'h00);
        rd_chk("wrap_rd_flag", 1'b1, 7'h05, 8'h80);
        rd_chk("wrap_rd_fast", 1'b1, 7'h04, 8'hFE);

        // timer write in the wrap cycle
        wr_cyc(1'b1, 7'h14, 8'd0);
        wr_cyc(1'b1, 7'h15, 8'h33);
        rd_chk("wrap_wr_flag", 1'b1, 7'h05, 8'h00);
        rd_chk("wrap_wr_timer", 1'b1, 7'h04, 8'h33);

        // reset mid-countdown, V=50, D=8
        wr_cyc(1'b1, 7'h1D, 8'd50);
        repeat (99) @(negedge CLK);
        RES = 1'b1;
        #1;
        chk("mid_pa_out", PA_out, 8'h00);
        chk("mid_pa_oe", PA_oe, 8'h00);
        chk("mid_pb_out", PB_out, 8'h00);
        chk("mid_pb_oe", PB_oe, 8'h00);
        chk("mid_irq", {7'b0, IRQ_n}, 8'h01);
        #1 RES = 1'b0;
        rd_chk("mid_timer", 1'b1, 7'h04, 8'hFF);
        rd_chk("mid_flag", 1'b1, 7'h05, 8'h00);
        rd_chk("mid_ram00", 1'b0, 7'h00, 8'hA5);
        rd_chk("mid_ram7f", 1'b0, 7'h7F, 8'h3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
